// File: rtl/regfile_2r1w_be.sv
// DEPTH x WIDTH register file: one byte-enabled write port, two registered read ports
// with write-first bypass, and a sweep-clear engine that zeroes one entry per cycle.
module regfile_2r1w_be #(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              WrEn,
   input  logic [ADDR_W-1:0] WrAddr,
   input  logic [WIDTH-1:0]  WrData,
   input  logic [WIDTH/8-1:0] WrBe,
   input  logic              RdEnA,
   input  logic [ADDR_W-1:0] RdAddrA,
   output logic [WIDTH-1:0]  RdDataA,
   output logic              RdValidA,
   input  logic              RdEnB,
   input  logic [ADDR_W-1:0] RdAddrB,
   output logic [WIDTH-1:0]  RdDataB,
   output logic              RdValidB,
   input  logic              ClrReq,
   output logic              Busy,
   output logic              DbgState,
   output logic [ADDR_W-1:0] DbgPtr
);

   localparam int BE_W = WIDTH / 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [WIDTH-1:0]  mem [DEPTH];

   logic              wr_in_range;
   logic              wr_ok;
   logic [WIDTH-1:0]  wr_word;
   logic [WIDTH-1:0]  rd_word_a;
   logic [WIDTH-1:0]  rd_word_b;

   assign wr_in_range = int'(WrAddr) < DEPTH;
   // A ClrReq edge in IDLE drops the coincident write, which also removes it from bypass.
   assign wr_ok = (state == IDLE) && WrEn && !ClrReq && wr_in_range;

   // Stored word with the enabled lanes replaced by WrData.
   always_comb begin
      wr_word = '0;
      if (wr_in_range) begin
         wr_word = mem[WrAddr];
      end
      for (int i = 0; i < BE_W; i++) begin
         if (WrBe[i]) begin
            wr_word[8*i +: 8] = WrData[8*i +: 8];
         end
      end
   end

   always_comb begin
      rd_word_a = '0;
      if (int'(RdAddrA) < DEPTH) begin
         rd_word_a = (wr_ok && (RdAddrA == WrAddr)) ? wr_word : mem[RdAddrA];
      end
   end

   always_comb begin
      rd_word_b = '0;
      if (int'(RdAddrB) < DEPTH) begin
         rd_word_b = (wr_ok && (RdAddrB == WrAddr)) ? wr_word : mem[RdAddrB];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         state    <= IDLE;
         ptr      <= '0;
         Busy     <= 1'b0;
         RdDataA  <= '0;
         RdDataB  <= '0;
         RdValidA <= 1'b0;
         RdValidB <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               RdValidA <= RdEnA;
               RdValidB <= RdEnB;
               if (RdEnA) begin
                  RdDataA <= rd_word_a;
               end
               if (RdEnB) begin
                  RdDataB <= rd_word_b;
               end
               if (wr_ok) begin
                  mem[WrAddr] <= wr_word;
               end
               if (ClrReq) begin
                  state <= CLEAR;
                  ptr   <= '0;
                  Busy  <= 1'b1;
               end
            end
            CLEAR: begin
               // Ports are frozen: no valids, read data holds its last value.
               RdValidA <= 1'b0;
               RdValidB <= 1'b0;
               mem[ptr] <= '0;
               if (int'(ptr) == DEPTH - 1) begin
                  state <= IDLE;
                  ptr   <= '0;
                  Busy  <= 1'b0;
               end else begin
                  ptr <= ptr + ADDR_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

   assign DbgState = (state == CLEAR);
   assign DbgPtr   = ptr;

endmodule

// File: tb/tb_regfile_2r1w_be.sv
// Bench for regfile_2r1w_be: a DEPTH=8 and a DEPTH=6 instance share all inputs and are
// checked every cycle against an array model, plus a vector table and directed sequences.
module tb_regfile_2r1w_be;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic [1:0]  wr_be = '0;
   logic        rd_en_a = 1'b0;
   logic [2:0]  rd_addr_a = '0;
   logic        rd_en_b = 1'b0;
   logic [2:0]  rd_addr_b = '0;
   logic        clr_req = 1'b0;

   logic [15:0] rda [2];
   logic [15:0] rdb [2];
   logic        va [2];
   logic        vb [2];
   logic        busy [2];
   logic        dbg_state [2];
   logic [2:0]  dbg_ptr [2];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   regfile_2r1w_be #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) dut (
      .CLK(clk), .RST(rst), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrBe(wr_be),
      .RdEnA(rd_en_a), .RdAddrA(rd_addr_a), .RdDataA(rda[0]), .RdValidA(va[0]),
      .RdEnB(rd_en_b), .RdAddrB(rd_addr_b), .RdDataB(rdb[0]), .RdValidB(vb[0]),
      .ClrReq(clr_req), .Busy(busy[0]), .DbgState(dbg_state[0]), .DbgPtr(dbg_ptr[0])
   );

   regfile_2r1w_be #(.WIDTH(16), .DEPTH(6), .ADDR_W(3)) dut6 (
      .CLK(clk), .RST(rst), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrBe(wr_be),
      .RdEnA(rd_en_a), .RdAddrA(rd_addr_a), .RdDataA(rda[1]), .RdValidA(va[1]),
      .RdEnB(rd_en_b), .RdAddrB(rd_addr_b), .RdDataB(rdb[1]), .RdValidB(vb[1]),
      .ClrReq(clr_req), .Busy(busy[1]), .DbgState(dbg_state[1]), .DbgPtr(dbg_ptr[1])
   );

   // ---------------- reference model ----------------
   logic [15:0] m_mem [2][8];
   int          m_left [2];
   logic [15:0] m_rda [2];
   logic [15:0] m_rdb [2];
   logic        m_va [2];
   logic        m_vb [2];

   function automatic int depth_of(input int k);
      return (k == 0) ? 8 : 6;
   endfunction

   task automatic model_step(input int k);
      int          d;
      logic        wok;
      logic [15:0] nw;
      d = depth_of(k);
      if (m_left[k] > 0) begin
         m_mem[k][d - m_left[k]] = '0;
         m_left[k] = m_left[k] - 1;
         m_va[k] = 1'b0;
         m_vb[k] = 1'b0;
      end else begin
         wok = wr_en && !clr_req && (int'(wr_addr) < d);
         nw = m_mem[k][wr_addr];
         for (int i = 0; i < 2; i++) begin
            if (wr_be[i]) nw[8*i +: 8] = wr_data[8*i +: 8];
         end
         m_va[k] = rd_en_a;
         m_vb[k] = rd_en_b;
         if (rd_en_a) begin
            if (int'(rd_addr_a) >= d) m_rda[k] = '0;
            else if (wok && rd_addr_a == wr_addr) m_rda[k] = nw;
            else m_rda[k] = m_mem[k][rd_addr_a];
         end
         if (rd_en_b) begin
            if (int'(rd_addr_b) >= d) m_rdb[k] = '0;
            else if (wok && rd_addr_b == wr_addr) m_rdb[k] = nw;
            else m_rdb[k] = m_mem[k][rd_addr_b];
         end
         if (wok) m_mem[k][wr_addr] = nw;
         if (clr_req) m_left[k] = d;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 8; a++) m_mem[k][a] = '0;
            m_left[k] = 0;
            m_rda[k]  = '0;
            m_rdb[k]  = '0;
            m_va[k]   = 1'b0;
            m_vb[k]   = 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) model_step(k);
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rda[%0d]", k), 32'(rda[k]), 32'(m_rda[k]));
         chk($sformatf("rdb[%0d]", k), 32'(rdb[k]), 32'(m_rdb[k]));
         chk($sformatf("va[%0d]", k), 32'(va[k]), 32'(m_va[k]));
         chk($sformatf("vb[%0d]", k), 32'(vb[k]), 32'(m_vb[k]));
         chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_left[k] > 0));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_be = '0; rd_en_a = 1'b0; rd_en_b = 1'b0; clr_req = 1'b0;
   endtask

   task automatic do_write(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
      idle_inputs();
      wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
      tick();
      idle_inputs();
   endtask

   task automatic do_read(input logic ea, input logic [2:0] aa, input logic eb, input logic [2:0] ab);
      idle_inputs();
      rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
      tick();
      idle_inputs();
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy[0] || busy[1]) && n < 40) begin
         tick();
         n++;
      end
      chk({name, "_idle_timeout"}, 32'(busy[0] || busy[1]), 32'd0);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  wa;
      logic [15:0] wd;
      logic [1:0]  be;
      logic        rea;
      logic [2:0]  ra;
      logic        reb;
      logic [2:0]  rb;
      logic [15:0] exp_a;
      logic        exp_va;
      logic [15:0] exp_b;
      logic        exp_vb;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int cycles;
      vecs[0] = '{1'b1, 3'd5, 16'hBEEF, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[1] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd5, 1'b0, 3'd0, 16'hBEEF, 1'b1, 16'h0000, 1'b0};
      vecs[2] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
      vecs[3] = '{1'b1, 3'd2, 16'h1234, 2'b11, 1'b0, 3'd0, 1'b0, 3'd0, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
      vecs[4] = '{1'b1, 3'd2, 16'hAB00, 2'b10, 1'b1, 3'd2, 1'b1, 3'd2, 16'hAB34, 1'b1, 16'hAB34, 1'b1};
      vecs[5] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd2, 1'b0, 3'd0, 16'hAB34, 1'b1, 16'hAB34, 1'b0};
      vecs[6] = '{1'b1, 3'd2, 16'h00FF, 2'b00, 1'b0, 3'd0, 1'b1, 3'd2, 16'hAB34, 1'b0, 16'hAB34, 1'b1};
      vecs[7] = '{1'b0, 3'd0, 16'h0000, 2'b00, 1'b1, 3'd7, 1'b0, 3'd0, 16'h0000, 1'b1, 16'hAB34, 1'b0};

      // reset
      idle_inputs();
      @(negedge clk);
      tick();
      rst = 1'b0;
      tick();
      chk("reset_busy", 32'(busy[0]), 32'd0);
      chk("reset_rda", 32'(rda[0]), 32'd0);

      // vector table on the DEPTH=8 instance
      for (int i = 0; i < 8; i++) begin
         idle_inputs();
         wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd; wr_be = vecs[i].be;
         rd_en_a = vecs[i].rea; rd_addr_a = vecs[i].ra; rd_en_b = vecs[i].reb; rd_addr_b = vecs[i].rb;
         tick();
         chk($sformatf("vec%0d_rda", i), 32'(rda[0]), 32'(vecs[i].exp_a));
         chk($sformatf("vec%0d_va", i), 32'(va[0]), 32'(vecs[i].exp_va));
         chk($sformatf("vec%0d_rdb", i), 32'(rdb[0]), 32'(vecs[i].exp_b));
         chk($sformatf("vec%0d_vb", i), 32'(vb[0]), 32'(vecs[i].exp_vb));
      end
      idle_inputs();

      // sweep clear with writes/reads issued mid-clear
      for (int k = 0; k < 8; k++) do_write(3'(k), 16'(16'h1111 * k), 2'b11);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      cycles = 0;
      while (busy[0] && cycles < 20) begin
         cycles++;
         idle_inputs();
         if (cycles == 6) begin
            wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hFFFF; wr_be = 2'b11;
            rd_en_a = 1'b1; rd_addr_a = 3'd4;
         end
         tick();
         if (cycles == 6) chk("clear_va_mid", 32'(va[0]), 32'd0);
      end
      idle_inputs();
      chk("clear_busy_len", 32'(cycles), 32'd8);
      wait_idle("clear1");
      do_read(1'b1, 3'd3, 1'b1, 3'd7);
      chk("clear_rd3", 32'(rda[0]), 32'd0);
      chk("clear_rd7", 32'(rdb[0]), 32'd0);
      chk("clear_va", 32'(va[0]), 32'd1);

      // ClrReq with coincident write and read
      do_write(3'd1, 16'h0F0F, 2'b11);
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h5555; wr_be = 2'b11;
      rd_en_b = 1'b1; rd_addr_b = 3'd1; clr_req = 1'b1;
      tick();
      idle_inputs();
      chk("clrw_rdb", 32'(rdb[0]), 32'h0F0F);
      chk("clrw_vb", 32'(vb[0]), 32'd1);
      wait_idle("clear2");
      do_read(1'b0, 3'd0, 1'b1, 3'd1);
      chk("clrw_after", 32'(rdb[0]), 32'd0);

      // out-of-range address on the DEPTH=6 instance
      for (int k = 0; k < 6; k++) do_write(3'(k), 16'(16'h0101 * (k + 1)), 2'b11);
      do_write(3'd6, 16'h7777, 2'b11);
      do_read(1'b1, 3'd6, 1'b0, 3'd0);
      chk("oor6_rda", 32'(rda[1]), 32'd0);
      chk("oor6_va", 32'(va[1]), 32'd1);
      chk("oor8_rda", 32'(rda[0]), 32'h7777);
      for (int k = 0; k < 6; k++) begin
         do_read(1'b1, 3'(k), 1'b0, 3'd0);
         chk($sformatf("oor6_keep%0d", k), 32'(rda[1]), 32'(16'h0101 * (k + 1)));
      end

      // randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         wr_en     = 1'($urandom_range(0, 1));
         wr_addr   = 3'($urandom_range(0, 7));
         wr_data   = 16'($urandom);
         wr_be     = 2'($urandom_range(0, 3));
         rd_en_a   = 1'($urandom_range(0, 1));
         rd_addr_a = 3'($urandom_range(0, 7));
         rd_en_b   = 1'($urandom_range(0, 1));
         rd_addr_b = 3'($urandom_range(0, 7));
         clr_req   = ($urandom_range(0, 39) == 0);
         tick();
      end
      idle_inputs();
      wait_idle("random");

      // asynchronous reset in the middle of a sweep
      do_write(3'd4, 16'hA5A5, 2'b11);
      do_read(1'b1, 3'd4, 1'b1, 3'd4);
      chk("pre_rst_rda", 32'(rda[0]), 32'hA5A5);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      cycles = 0;
      while (dbg_ptr[0] != 3'd3 && cycles < 20) begin
         tick();
         cycles++;
      end
      chk("rst_ptr_reached", 32'(dbg_ptr[0]), 32'd3);
      chk("rst_in_clear", 32'(dbg_state[0]), 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy[0]), 32'd0);
      chk("arst_busy6", 32'(busy[1]), 32'd0);
      chk("arst_rda", 32'(rda[0]), 32'd0);
      chk("arst_rdb", 32'(rdb[0]), 32'd0);
      chk("arst_va", 32'(va[0] | vb[0]), 32'd0);
      check_all();
      tick();
      rst = 1'b0;
      do_write(3'd0, 16'h1234, 2'b11);
      do_read(1'b1, 3'd0, 1'b1, 3'd4);
      chk("post_rst_wr", 32'(rda[0]), 32'h1234);
      chk("post_rst_zero", 32'(rdb[0]), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
